pwm_mixer_array: RTL and testbench

//   N-channel encoder-to-PWM mixer; generalised successor of the fixed 3-channel RGB mixer.
//   Per channel: 2-flop synchroniser, debouncer, x1 quadrature decoder with wrap/saturate mode, PWM generator.
//   All logic runs on clk12, gated by one shared clock-enable tick. No derived clocks.

---
 rtl/pwm_mixer_array.sv | 99 +++++++++
 tb/tb_pwm_mixer_array.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_mixer_array.sv
// N-channel quadrature-encoder to PWM mixer: each channel synchronises, debounces and x1-decodes its encoder.
// The encoder drives a level register that sets the duty cycle of a shared-counter PWM. All state advances on one clk12 tick.
module pwm_mixer_array #(
  parameter int NUM_CH    = 3,
  parameter int DIV_COUNT = 240,
  parameter int HIST_LEN  = 8,
  parameter int PWM_WIDTH = 8,
  parameter int STEP      = 1,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                        clk12,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enc_a,
  input  logic [NUM_CH-1:0]           enc_b,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic [NUM_CH*PWM_WIDTH-1:0] level,
  output logic                        tick
);
  localparam int DW = $clog2(DIV_COUNT);
  localparam logic [DW-1:0]        DIV_LAST = DW'(DIV_COUNT - 1);
  localparam logic [DW-1:0]        DIV_PRE  = DW'(DIV_COUNT - 2);
  localparam logic [PWM_WIDTH:0]   STEP_X   = (PWM_WIDTH + 1)'(STEP);
  localparam logic [PWM_WIDTH-1:0] LVL_MAX  = '1;

  logic [DW-1:0]        div_cnt;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [NUM_CH-1:0]    a_s1, a_s2, b_s1, b_s2;

  // tick is registered one cycle early so it is high exactly while div_cnt sits at its last value
  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      tick    <= (div_cnt == DIV_PRE);
    end
  end

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      a_s1 <= '0;
      a_s2 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      b_s1 <= enc_b;
      b_s2 <= b_s1;
    end
  end

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset)     pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [HIST_LEN-1:0]  hist_a, hist_b;
    logic                 db_a, db_b, prev_a, pwm_q;
    logic [PWM_WIDTH-1:0] lvl, lvl_up, lvl_dn;
    logic [PWM_WIDTH:0]   up_sum, dn_diff;

    // one extra bit catches overflow on the way up and borrow on the way down
    always_comb begin
      up_sum  = {1'b0, lvl} + STEP_X;
      dn_diff = {1'b0, lvl} - STEP_X;
      lvl_up  = (SATURATE && up_sum[PWM_WIDTH])  ? LVL_MAX : up_sum[PWM_WIDTH-1:0];
      lvl_dn  = (SATURATE && dn_diff[PWM_WIDTH]) ? '0      : dn_diff[PWM_WIDTH-1:0];
    end

    always_ff @(posedge clk12 or posedge reset) begin
      if (reset) begin
        hist_a <= '0;
        hist_b <= '0;
        db_a   <= 1'b0;
        db_b   <= 1'b0;
        prev_a <= 1'b0;
        lvl    <= '0;
        pwm_q  <= 1'b0;
      end else if (tick) begin
        hist_a <= {hist_a[HIST_LEN-2:0], a_s2[i]};
        hist_b <= {hist_b[HIST_LEN-2:0], b_s2[i]};
        if (&hist_a)       db_a <= 1'b1;
        else if (~|hist_a) db_a <= 1'b0;
        if (&hist_b)       db_b <= 1'b1;
        else if (~|hist_b) db_b <= 1'b0;
        prev_a <= db_a;
        if (db_a && !prev_a) lvl <= db_b ? lvl_dn : lvl_up;
        pwm_q <= (pwm_cnt < lvl);
      end
    end

    assign level[i*PWM_WIDTH +: PWM_WIDTH] = lvl;
    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_mixer_array.sv
// Bench for pwm_mixer_array: a saturating and a wrapping instance share stimulus and are checked every tick
// against a tick-level model built from stable-run counting and plain level arithmetic.
`timescale 1ns/1ps
module tb_pwm_mixer_array;
  localparam int NCH  = 3;
  localparam int DIV  = 4;
  localparam int HL   = 4;
  localparam int PW   = 4;
  localparam int STP  = 1;
  localparam int LMAX = (1 << PW) - 1;

  logic            clk12 = 1'b0;
  logic            reset = 1'b0;
  logic [NCH-1:0]  enc_a = '0;
  logic [NCH-1:0]  enc_b = '0;
  logic [NCH-1:0]  pwm_s, pwm_w;
  logic [NCH*PW-1:0] level_s, level_w;
  logic            tick_s, tick_w;

  always #5 clk12 = ~clk12;

  pwm_mixer_array #(.NUM_CH(NCH), .DIV_COUNT(DIV), .HIST_LEN(HL), .PWM_WIDTH(PW),
                    .STEP(STP), .SATURATE(1'b1)) dut_sat (
    .clk12(clk12), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .pwm_out(pwm_s), .level(level_s), .tick(tick_s));

  pwm_mixer_array #(.NUM_CH(NCH), .DIV_COUNT(DIV), .HIST_LEN(HL), .PWM_WIDTH(PW),
                    .STEP(STP), .SATURATE(1'b0)) dut_wrap (
    .clk12(clk12), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .pwm_out(pwm_w), .level(level_w), .tick(tick_w));

  int total = 0;
  int bad   = 0;

  // model: per input the last sample and how many ticks in a row it has been seen
  int m_last_a[NCH], m_run_a[NCH], m_last_b[NCH], m_run_b[NCH];
  int m_db_a[NCH], m_db_b[NCH], m_prev[NCH];
  int m_lvl_s[NCH], m_lvl_w[NCH], m_pwm_s[NCH], m_pwm_w[NCH];
  int m_pcnt;
  int hi_s[NCH];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_last_a[c] = 0; m_run_a[c] = HL;
      m_last_b[c] = 0; m_run_b[c] = HL;
      m_db_a[c] = 0; m_db_b[c] = 0; m_prev[c] = 0;
      m_lvl_s[c] = 0; m_lvl_w[c] = 0; m_pwm_s[c] = 0; m_pwm_w[c] = 0;
    end
    m_pcnt = 0;
  endtask

  task automatic deb(inout int last, inout int run, inout int db, input int s);
    if (run >= HL) db = last;
    if (s == last) run++;
    else begin
      last = s;
      run  = 1;
    end
  endtask

  task automatic model_tick(input logic [NCH-1:0] a, input logic [NCH-1:0] b);
    int d, t;
    for (int c = 0; c < NCH; c++) begin
      m_pwm_s[c] = (m_pcnt < m_lvl_s[c]) ? 1 : 0;
      m_pwm_w[c] = (m_pcnt < m_lvl_w[c]) ? 1 : 0;
      if (m_db_a[c] == 1 && m_prev[c] == 0) begin
        d = (m_db_b[c] == 1) ? -STP : STP;
        t = m_lvl_s[c] + d;
        m_lvl_s[c] = (t < 0) ? 0 : (t > LMAX) ? LMAX : t;
        m_lvl_w[c] = ((m_lvl_w[c] + d) % (LMAX + 1) + (LMAX + 1)) % (LMAX + 1);
      end
      m_prev[c] = m_db_a[c];
      deb(m_last_a[c], m_run_a[c], m_db_a[c], int'(a[c]));
      deb(m_last_b[c], m_run_b[c], m_db_b[c], int'(b[c]));
    end
    m_pcnt = (m_pcnt + 1) % (LMAX + 1);
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("level_sat[%0d]", c),  int'(level_s[c*PW +: PW]), m_lvl_s[c]);
      check($sformatf("level_wrap[%0d]", c), int'(level_w[c*PW +: PW]), m_lvl_w[c]);
      check($sformatf("pwm_sat[%0d]", c),    int'(pwm_s[c]), m_pwm_s[c]);
      check($sformatf("pwm_wrap[%0d]", c),   int'(pwm_w[c]), m_pwm_w[c]);
    end
  endtask

  // Entered #1 after a tick edge; inputs are held for the whole interval up to the next tick edge.
  task automatic run_tick(input logic [NCH-1:0] a, input logic [NCH-1:0] b);
    int waited;
    waited = 0;
    enc_a = a;
    enc_b = b;
    while (tick_s !== 1'b1 && waited < 2 * DIV) begin
      @(posedge clk12); #1;
      waited++;
    end
    if (tick_s !== 1'b1) begin
      check("tick_wait", 0, 1);
      return;
    end
    @(posedge clk12); #1;
    model_tick(a, b);
    compare_all();
    for (int c = 0; c < NCH; c++) hi_s[c] += int'(pwm_s[c]);
  endtask

  task automatic detent(input logic [NCH-1:0] up, input logic [NCH-1:0] dn, input int ph);
    repeat (ph) run_tick(up | dn, dn);
    repeat (ph) run_tick('0, '0);
  endtask

  task automatic idle_count(input int n);
    for (int c = 0; c < NCH; c++) hi_s[c] = 0;
    repeat (n) run_tick('0, '0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      check("rst_level_sat",  int'(level_s[c*PW +: PW]), 0);
      check("rst_level_wrap", int'(level_w[c*PW +: PW]), 0);
    end
    check("rst_pwm_sat",  int'(pwm_s), 0);
    check("rst_pwm_wrap", int'(pwm_w), 0);
    check("rst_tick",     int'(tick_s), 0);
    enc_a = '0;
    enc_b = '0;
    model_reset();
    repeat (3) @(posedge clk12);
    #1 reset = 1'b0;
    for (int n = 1; n <= 3 * DIV; n++) begin
      @(posedge clk12); #1;
      check("tick_sat",  int'(tick_s), ((n % DIV) == DIV - 1) ? 1 : 0);
      check("tick_wrap", int'(tick_w), ((n % DIV) == DIV - 1) ? 1 : 0);
      if (n % DIV == 0) begin
        model_tick('0, '0);
        compare_all();
      end
    end
  endtask

  initial begin
    logic [NCH-1:0] ra, rb;
    int hold;
    do_reset();

    // up count on ch1
    repeat (5) detent(3'b010, 3'b000, 8);
    check("up_ch1", int'(level_s[1*PW +: PW]), 5);
    idle_count(16);
    check("up_duty_ch1", hi_s[1], 5);

    // saturation on ch0
    repeat (20) detent(3'b001, 3'b000, 6);
    check("sat_hi", int'(level_s[0 +: PW]), LMAX);
    idle_count(16);
    check("sat_hi_duty", hi_s[0], LMAX);
    repeat (20) detent(3'b000, 3'b001, 6);
    check("sat_lo", int'(level_s[0 +: PW]), 0);
    idle_count(16);
    check("sat_lo_duty", hi_s[0], 0);

    // wrap instance across zero
    check("wrap_start", int'(level_w[0 +: PW]), 0);
    detent(3'b000, 3'b001, 8);
    check("wrap_down", int'(level_w[0 +: PW]), LMAX);
    check("sat_floor", int'(level_s[0 +: PW]), 0);
    detent(3'b001, 3'b000, 8);
    check("wrap_up", int'(level_w[0 +: PW]), 0);

    // debounce on ch2: short glitch, then a clean pulse with latency check
    repeat (3) run_tick(3'b100, 3'b000);
    repeat (8) run_tick(3'b000, 3'b000);
    check("glitch_ch2", int'(level_s[2*PW +: PW]), 0);
    repeat (5) run_tick(3'b100, 3'b000);
    check("db_early_ch2", int'(level_s[2*PW +: PW]), 0);
    run_tick(3'b100, 3'b000);
    check("db_late_ch2", int'(level_s[2*PW +: PW]), 1);
    repeat (8) run_tick(3'b000, 3'b000);
    check("db_once_ch2", int'(level_s[2*PW +: PW]), 1);

    // bring ch0 and ch2 to 7, then move them in opposite directions on the same ticks
    repeat (6) detent(3'b101, 3'b000, 6);
    check("pre_sim_ch0", int'(level_s[0 +: PW]), 7);
    check("pre_sim_ch2", int'(level_s[2*PW +: PW]), 7);
    detent(3'b001, 3'b100, 6);
    check("sim_ch0", int'(level_s[0 +: PW]), 8);
    check("sim_ch2", int'(level_s[2*PW +: PW]), 6);

    // random encoder activity, held for whole tick intervals
    for (int k = 0; k < 40; k++) begin
      ra = NCH'($urandom);
      rb = NCH'($urandom);
      hold = $urandom_range(1, 10);
      repeat (hold) run_tick(ra, rb);
    end

    // reset while ch1 is part-way through debouncing a rising A
    repeat (3) run_tick(3'b010, 3'b000);
    do_reset();
    repeat (10) run_tick(3'b000, 3'b000);
    check("post_rst_ch1", int'(level_s[1*PW +: PW]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
